// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with saturating direction counters; same-cycle next-PC prediction, trained by EX resolution.
// Latency: lookup and mispredict/redirect are combinational (0 cycles); table updates visible the cycle after the write edge.
// Backpressure: none; every upd_valid cycle is consumed exactly once, lookups are always answered.
module branch_target_predictor #(
    parameter int ENTRIES   = 32,
    parameter int WIDTH     = 32,
    parameter int CNT_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_en,
    input  logic [WIDTH-1:0]     lookup_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [WIDTH-1:0]     pred_target,
    input  logic                 upd_valid,
    input  logic                 upd_is_jump,
    input  logic [WIDTH-1:0]     upd_pc,
    input  logic                 upd_taken,
    input  logic [WIDTH-1:0]     upd_target,
    input  logic                 upd_pred_taken,
    input  logic [WIDTH-1:0]     upd_pred_target,
    output logic                 mispredict,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic [STAT_BITS-1:0] stat_lookups,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH - IDX_W - 2;

    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [WIDTH-1:0]     WORD_MSK = ~WIDTH'(3);
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    // Table storage; only the valid bits are reset, payload is don't-care until allocated.
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [WIDTH-1:0]    tgt_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [WIDTH-1:0] lk_seq;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic [WIDTH-1:0] up_seq;
    logic             up_hit;
    logic [CNT_BITS-1:0] up_cnt;

    logic                ent_we;
    logic [TAG_W-1:0]    nxt_tag;
    logic [WIDTH-1:0]    nxt_tgt;
    logic [CNT_BITS-1:0] nxt_cnt;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[WIDTH-1:IDX_W+2];
    assign lk_seq = (lookup_pc & WORD_MSK) + WIDTH'(4);

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[WIDTH-1:IDX_W+2];
    assign up_seq = (upd_pc & WORD_MSK) + WIDTH'(4);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_cnt = cnt_q[up_idx];

    // Lookup straight off the registered table, so a same-cycle update is not seen (read-before-write).
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnt_q[lk_idx][CNT_BITS-1];
        pred_target = pred_taken ? tgt_q[lk_idx] : lk_seq;
    end

    // Redirect decision depends only on what EX resolved versus what travelled down the pipe.
    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : up_seq;
    end

    // Training: compute the new contents of the indexed entry; a not-taken jump trains like a branch.
    always_comb begin
        ent_we  = 1'b0;
        nxt_tag = up_tag;
        nxt_tgt = upd_target;
        nxt_cnt = up_cnt;
        if (upd_valid) begin
            if (up_hit) begin
                ent_we = 1'b1;
                if (upd_taken) begin
                    if (upd_is_jump)
                        nxt_cnt = CNT_MAX;
                    else if (up_cnt != CNT_MAX)
                        nxt_cnt = up_cnt + CNT_BITS'(1);
                end else begin
                    nxt_tgt = tgt_q[up_idx];
                    if (up_cnt != '0)
                        nxt_cnt = up_cnt - CNT_BITS'(1);
                end
            end else if (upd_taken) begin
                ent_we  = 1'b1;
                nxt_cnt = upd_is_jump ? CNT_MAX : CNT_WEAK;
            end
        end
    end

    // Valid bits: reset clears all and wins over a coincident update, so no partial entry survives.
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else if (ent_we)
            valid_q[up_idx] <= 1'b1;
    end

    // Entry payload: written only on an accepted update; reset suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && ent_we) begin
            tag_q[up_idx] <= nxt_tag;
            tgt_q[up_idx] <= nxt_tgt;
            cnt_q[up_idx] <= nxt_cnt;
        end
    end

    // Performance counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_en && (stat_lookups != STAT_MAX))
                stat_lookups <= stat_lookups + STAT_BITS'(1);
            if (mispredict && (stat_mispredicts != STAT_MAX))
                stat_mispredicts <= stat_mispredicts + STAT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios plus randomized traffic against a table model.
// Latency: checks combinational outputs 1ns after the falling edge, model advances at the rising edge.
// Backpressure: none; each applied update is committed to the model exactly once.
module tb_branch_target_predictor;

    localparam int SB = 4;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lookup_en = 1'b0;
    logic [31:0]   lookup_pc = '0;
    logic          pred_hit, pred_taken;
    logic [31:0]   pred_target;
    logic          upd_valid = 1'b0, upd_is_jump = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic [31:0]   upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic [SB-1:0] stat_lookups, stat_mispredicts;

    int vecs = 0;
    int errs = 0;

    // Reference model: per-slot full PC of the occupant, target and counter value 0..3.
    bit          m_valid [32];
    logic [31:0] m_pc    [32];
    logic [31:0] m_tgt   [32];
    int          m_cnt   [32];
    int          m_lk = 0;
    int          m_mp = 0;

    branch_target_predictor #(.ENTRIES(32), .WIDTH(32), .CNT_BITS(2), .STAT_BITS(SB)) dut (
        .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 32);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && ((m_pc[slot(pc)] / 128) == (pc / 128));
    endfunction

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        logic [31:0] r;
        r = (pc / 4) * 4 + 32'd4;
        return r;
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : seq_pc(pc);
    endfunction

    function automatic bit m_mispredict();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic apply(input bit r, input bit le, input logic [31:0] lpc,
                         input bit uv, input bit uj, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utg, input bit upt, input logic [31:0] uptg);
        @(negedge clk);
        rst = r; lookup_en = le; lookup_pc = lpc;
        upd_valid = uv; upd_is_jump = uj; upd_pc = upc; upd_taken = ut;
        upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
        #1;
    endtask

    task automatic look(input logic [31:0] lpc);
        apply(0, 1, lpc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock and apply the same cycle's rules to the model.
    task automatic commit();
        bit mp;
        int i;
        mp = m_mispredict();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) m_valid[k] = 1'b0;
            m_lk = 0;
            m_mp = 0;
        end else begin
            if (lookup_en && m_lk < SMAX) m_lk++;
            if (mp && m_mp < SMAX) m_mp++;
            if (upd_valid) begin
                i = slot(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_tgt[i] = upd_target;
                        m_cnt[i] = upd_is_jump ? 3 : ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3);
                    end else begin
                        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_pc[i]    = upd_pc;
                    m_tgt[i]   = upd_target;
                    m_cnt[i]   = upd_is_jump ? 3 : 2;
                end
            end
        end
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        commit();
    endtask

    task automatic test_reset();
        do_reset();
        look(32'h0000_0040);
        vecs++; if (pred_hit !== 1'b0) begin errs++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
        vecs++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        vecs++; if (pred_target !== 32'h44) begin errs++; $display("FAIL reset_target: got %h want 00000044", pred_target); end
        vecs++; if (mispredict !== 1'b0) begin errs++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
        vecs++; if (stat_lookups !== 4'd0 || stat_mispredicts !== 4'd0)
            begin errs++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_lookups, stat_mispredicts); end
        commit();
    endtask

    task automatic test_alloc();
        do_reset();
        apply(0, 0, 0, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        vecs++; if (mispredict !== 1'b1) begin errs++; $display("FAIL alloc_mispredict: got %b want 1", mispredict); end
        vecs++; if (redirect_pc !== 32'h80) begin errs++; $display("FAIL alloc_redirect: got %h want 00000080", redirect_pc); end
        commit();
        look(32'h100);
        vecs++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1)
            begin errs++; $display("FAIL alloc_lookup: got hit=%b taken=%b want 1/1", pred_hit, pred_taken); end
        vecs++; if (pred_target !== 32'h80) begin errs++; $display("FAIL alloc_target: got %h want 00000080", pred_target); end
        commit();
        vecs++; if (stat_mispredicts !== 4'd1) begin errs++; $display("FAIL alloc_stat_mp: got %0d want 1", stat_mispredicts); end
    endtask

    task automatic test_counter();
        bit outcome [6] = '{0, 0, 0, 0, 1, 1};
        bit want    [6] = '{0, 0, 0, 0, 0, 1};
        do_reset();
        apply(0, 0, 0, 1, 0, 32'h100, 1, 32'h80, 0, 0);
        commit();
        for (int k = 0; k < 6; k++) begin
            apply(0, 0, 0, 1, 0, 32'h100, outcome[k], 32'h80, 1, 32'h80);
            commit();
            look(32'h100);
            vecs++; if (pred_hit !== 1'b1 || pred_taken !== want[k])
                begin errs++; $display("FAIL counter_step%0d: got hit=%b taken=%b want 1/%b", k, pred_hit, pred_taken, want[k]); end
            commit();
        end
    endtask

    task automatic test_alias();
        do_reset();
        apply(0, 0, 0, 1, 0, 32'h100, 1, 32'h80, 0, 0);
        commit();
        apply(0, 0, 0, 1, 1, 32'h180, 1, 32'h300, 0, 0);
        commit();
        look(32'h100);
        vecs++; if (pred_hit !== 1'b0) begin errs++; $display("FAIL alias_evicted: got %b want 0", pred_hit); end
        commit();
        look(32'h180);
        vecs++; if (pred_hit !== 1'b1 || pred_target !== 32'h300)
            begin errs++; $display("FAIL alias_jump: got hit=%b target=%h want 1/00000300", pred_hit, pred_target); end
        commit();
        // a single not-taken keeps a saturated jump counter predicting taken
        apply(0, 0, 0, 1, 1, 32'h180, 0, 0, 1, 32'h300);
        commit();
        look(32'h180);
        vecs++; if (pred_taken !== 1'b1) begin errs++; $display("FAIL alias_cnt11: got %b want 1", pred_taken); end
        commit();
        apply(0, 1, 32'h100, 1, 0, 32'h100, 1, 32'h90, 0, 0);
        vecs++; if (pred_hit !== 1'b0) begin errs++; $display("FAIL alias_rbw: got %b want 0", pred_hit); end
        commit();
        look(32'h100);
        vecs++; if (pred_hit !== 1'b1 || pred_target !== 32'h90)
            begin errs++; $display("FAIL alias_after: got hit=%b target=%h want 1/00000090", pred_hit, pred_target); end
        commit();
    endtask

    task automatic test_target();
        do_reset();
        apply(0, 0, 0, 1, 0, 32'h200, 1, 32'h300, 0, 0);
        commit();
        apply(0, 0, 0, 1, 0, 32'h200, 1, 32'h340, 1, 32'h300);
        vecs++; if (mispredict !== 1'b1 || redirect_pc !== 32'h340)
            begin errs++; $display("FAIL tgt_change: got mp=%b redirect=%h want 1/00000340", mispredict, redirect_pc); end
        commit();
        look(32'h200);
        vecs++; if (pred_target !== 32'h340) begin errs++; $display("FAIL tgt_stored: got %h want 00000340", pred_target); end
        commit();
        apply(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 32'h1234, 1, 32'h1234);
        vecs++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0)
            begin errs++; $display("FAIL tgt_wrap: got mp=%b redirect=%h want 1/00000000", mispredict, redirect_pc); end
        commit();
        look(32'hFFFF_FFFE);
        vecs++; if (pred_target !== 32'h0) begin errs++; $display("FAIL lookup_wrap: got %h want 00000000", pred_target); end
        commit();
        apply(0, 0, 0, 1, 0, 32'h200, 1, 32'h340, 1, 32'h340);
        vecs++; if (mispredict !== 1'b0) begin errs++; $display("FAIL tgt_correct: got %b want 0", mispredict); end
        commit();
    endtask

    task automatic test_stat_sat();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            look(32'h40 + 32'(k * 4));
            if (k == 10) begin
                vecs++; if (stat_lookups !== 4'd10) begin errs++; $display("FAIL stat_mid: got %0d want 10", stat_lookups); end
            end
            commit();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs++; if (stat_lookups !== 4'd15) begin errs++; $display("FAIL stat_sat: got %0d want 15", stat_lookups); end
        commit();
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(0, 1, 0, 1, 0, 32'h100, 1, 32'h80, 0, 0);
        commit();
        apply(1, 1, 0, 1, 1, 32'h300, 1, 32'h500, 0, 0);
        commit();
        look(32'h300);
        vecs++; if (pred_hit !== 1'b0) begin errs++; $display("FAIL rstmid_alloc: got %b want 0", pred_hit); end
        vecs++; if (stat_lookups !== 4'd0 || stat_mispredicts !== 4'd0)
            begin errs++; $display("FAIL rstmid_stats: got %0d/%0d want 0/0", stat_lookups, stat_mispredicts); end
        commit();
        look(32'h100);
        vecs++; if (pred_hit !== 1'b0) begin errs++; $display("FAIL rstmid_old: got %b want 0", pred_hit); end
        commit();
    endtask

    task automatic test_random();
        logic [31:0] pool [8] = '{32'h100, 32'h180, 32'h200, 32'h104, 32'hFFFF_FFFC, 32'h1100, 32'h202, 32'h300};
        logic [31:0] lpc, upc, utg, uptg;
        bit r, le, uv, uj, ut, upt;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            le  = $urandom_range(0, 1);
            lpc = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
            uv  = ($urandom_range(0, 2) != 0);
            uj  = ($urandom_range(0, 3) == 0);
            upc = pool[$urandom_range(0, 7)];
            ut  = $urandom_range(0, 1);
            utg = pool[$urandom_range(0, 7)] + 32'h40;
            upt = $urandom_range(0, 1);
            uptg = $urandom_range(0, 1) ? utg : pool[$urandom_range(0, 7)];
            apply(r, le, lpc, uv, uj, upc, ut, utg, upt, uptg);
            vecs++; if (pred_hit !== m_hit(lpc)) begin errs++; $display("FAIL rnd_hit@%0d: got %b want %b", n, pred_hit, m_hit(lpc)); end
            vecs++; if (pred_taken !== m_taken(lpc)) begin errs++; $display("FAIL rnd_taken@%0d: got %b want %b", n, pred_taken, m_taken(lpc)); end
            vecs++; if (pred_target !== m_target(lpc)) begin errs++; $display("FAIL rnd_target@%0d: got %h want %h", n, pred_target, m_target(lpc)); end
            vecs++; if (mispredict !== m_mispredict()) begin errs++; $display("FAIL rnd_mp@%0d: got %b want %b", n, mispredict, m_mispredict()); end
            if (m_mispredict()) begin
                vecs++; if (redirect_pc !== (ut ? utg : seq_pc(upc)))
                    begin errs++; $display("FAIL rnd_redirect@%0d: got %h want %h", n, redirect_pc, ut ? utg : seq_pc(upc)); end
            end
            vecs++; if (int'(stat_lookups) != m_lk || int'(stat_mispredicts) != m_mp)
                begin errs++; $display("FAIL rnd_stats@%0d: got %0d/%0d want %0d/%0d", n, stat_lookups, stat_mispredicts, m_lk, m_mp); end
            commit();
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            m_valid[k] = 1'b0; m_pc[k] = '0; m_tgt[k] = '0; m_cnt[k] = 0;
        end
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_target();
        test_stat_sat();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1);
    end

endmodule
